// File: rtl/sm_input_conditioner.sv
// Board-input conditioner: per-bit polarity fix, 2-FF synchroniser and counter debounce.
// Emits debounced levels plus registered one-cycle press/release pulses.
module sm_input_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INVERT          = '0
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] pol;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt   [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  // Active-low pins are flipped before the synchroniser so everything downstream is active-high.
  assign pol = raw ^ INVERT;

  // NOTE: every next-state variable gets its default before the loop so no latch is inferred.
  always_comb begin
    stable_d = stable;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == TERMINAL) begin
        stable_d[i] = sync2[i];
        cnt_d[i]    = '0;
        rise_d[i]   = sync2[i];
        fall_d[i]   = ~sync2[i];
      end else begin
        cnt_d[i] = cnt[i] + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter array is a set of
  // independent registers (not a RAM), so it is cleared on reset like any other flop.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= pol;
      sync2      <= sync1;
      stable     <= stable_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= |(rise_d | fall_d);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_d[i];
    end
  end

endmodule
